// File: rtl/pulse_pkg.sv
// Shared defaults and FSM state encoding for the pulse meter.
package pulse_pkg;

  localparam int unsigned CNT_W_DEF = 35;
  localparam int unsigned MIN_W_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_HIGH      = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer plus registered edge detector for the measured input.
// Edges are suppressed after reset until the input has been seen low.
module pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [1:0] fill_q, fill_d;
  logic       seen_low_q, seen_low_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // fill_q[1] marks that s2_q carries a real sample rather than its reset value
  always_comb begin
    s1_d       = async_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    fill_d     = {fill_q[0], 1'b1};
    seen_low_d = seen_low_q | (fill_q[1] & ~s2_q);
    rise_d     = seen_low_q & s2_q & ~s3_q;
    fall_d     = seen_low_q & ~s2_q & s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      fill_q     <= 2'b00;
      seen_low_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      fill_q     <= fill_d;
      seen_low_q <= seen_low_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign level = s3_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high width and rise-to-rise period of an asynchronous pulse train,
// rejecting pulses shorter than MIN_W and flagging counter saturation.
module pulse_meter #(
  parameter int unsigned CNT_W = pulse_pkg::CNT_W_DEF,
  parameter int unsigned MIN_W = pulse_pkg::MIN_W_DEF
) (
  input  logic             clk_PM,
  input  logic             rst_PM_n,
  input  logic             PM_in,
  input  logic             PM_arm,
  output logic [CNT_W-1:0] PM_width,
  output logic [CNT_W-1:0] PM_period,
  output logic             PM_valid,
  output logic             PM_glitch,
  output logic             PM_ovf,
  output logic             PM_busy
);
  import pulse_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic in_level, in_rise, in_fall;

  pulse_sync u_sync (
    .clk      (clk_PM),
    .rst_n    (rst_PM_n),
    .async_in (PM_in),
    .level    (in_level),
    .rise     (in_rise),
    .fall     (in_fall)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             first_q, first_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             glitch_q, glitch_d;
  logic             busy_q, busy_d;

  // period_cnt counts cycles since the last accepted rise; cand holds it at each new rise
  always_comb begin
    state_d      = state_q;
    width_cnt_d  = width_cnt_q;
    period_cnt_d = period_cnt_q;
    cand_d       = cand_q;
    width_d      = width_q;
    period_d     = period_q;
    first_d      = first_q;
    ovf_d        = ovf_q;
    valid_d      = 1'b0;
    glitch_d     = 1'b0;

    if (!PM_arm) begin
      state_d      = S_IDLE;
      width_cnt_d  = '0;
      period_cnt_d = '0;
      cand_d       = '0;
      first_d      = 1'b1;
      ovf_d        = 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        if (period_cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                         period_cnt_d = period_cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: state_d = S_WAIT_RISE;
        S_WAIT_RISE: begin
          if (in_rise) begin
            state_d     = S_HIGH;
            width_cnt_d = CNT_W'(1);
            cand_d      = period_cnt_q;
          end
        end
        S_HIGH: begin
          if (in_fall) begin
            state_d = S_WAIT_RISE;
            if (width_cnt_q >= CNT_W'(MIN_W)) begin
              valid_d      = 1'b1;
              width_d      = width_cnt_q;
              period_d     = first_q ? '0 : cand_q;
              first_d      = 1'b0;
              // restart the period reference at the accepted rise
              period_cnt_d = (width_cnt_q == CNT_MAX) ? CNT_MAX : width_cnt_q + CNT_W'(1);
            end else begin
              glitch_d = 1'b1;
            end
          end else if (in_level) begin
            if (width_cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                        width_cnt_d = width_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_HIGH);
  end

  always_ff @(posedge clk_PM or negedge rst_PM_n) begin
    if (!rst_PM_n) begin
      state_q      <= S_IDLE;
      width_cnt_q  <= '0;
      period_cnt_q <= '0;
      cand_q       <= '0;
      width_q      <= '0;
      period_q     <= '0;
      first_q      <= 1'b1;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
      glitch_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_cnt_q  <= width_cnt_d;
      period_cnt_q <= period_cnt_d;
      cand_q       <= cand_d;
      width_q      <= width_d;
      period_q     <= period_d;
      first_q      <= first_d;
      ovf_q        <= ovf_d;
      valid_q      <= valid_d;
      glitch_q     <= glitch_d;
      busy_q       <= busy_d;
    end
  end

  assign PM_width  = width_q;
  assign PM_period = period_q;
  assign PM_valid  = valid_q;
  assign PM_glitch = glitch_q;
  assign PM_ovf    = ovf_q;
  assign PM_busy   = busy_q;

endmodule
